// File: rtl/pc_sequencer_pkg.sv
// Shared opcode codes, reset address default, sequencer state encoding and helpers.
package pc_sequencer_pkg;

   localparam logic [3:0] OP_B    = 4'hA;
   localparam logic [3:0] OP_CALL = 4'hC;
   localparam logic [3:0] OP_RET  = 4'hD;

   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   function automatic logic [15:0] sext8(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address stack: storage and entry count only; over/underflow policy lives in the caller.
// Ignored push when full and ignored pop when empty keep the count in range.
module ras_stack #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic [15:0] din,
   output logic [15:0] top,
   output logic        empty,
   output logic        full
);

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
   localparam logic [AW-1:0] ONE_IDX  = AW'(1);

   logic [15:0]   slot_q [DEPTH];
   logic [AW:0]   count_q, count_d;
   logic [AW-1:0] wr_idx, rd_idx;
   logic          do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign wr_idx  = count_q[AW-1:0];
   assign rd_idx  = count_q[AW-1:0] - ONE_IDX;
   assign top     = slot_q[rd_idx];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty & ~push;

   always_comb begin
      count_d = count_q;
      if (do_push)
         count_d = count_q + ONE_CNT;
      else if (do_pop)
         count_d = count_q - ONE_CNT;
   end

   always_ff @(posedge clk) begin
      if (rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   // Slots need no reset: the count gates every read that matters.
   always_ff @(posedge clk) begin
      if (do_push)
         slot_q[wr_idx] <= din;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential fetch, hazard hold, EX-resolved B/CALL/RET redirects with a RAS.
// if_pc is registered; flush_if is combinational from the current EX redirect decision.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int          RAS_DEPTH = 8,
   parameter int          RAS_AW    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hazard,
   input  logic        ex_valid,
   input  logic [15:0] ex_pc,
   input  logic [15:0] ex_instr,
   input  logic        branch,
   output logic [15:0] if_pc,
   output logic        if_valid,
   output logic        flush_if,
   output logic        ras_empty,
   output logic        ras_full,
   output logic        fault
);

   logic [1:0]  state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic        fault_q, fault_d;

   logic [3:0]  opcode;
   logic        is_b, is_call, is_ret;
   logic        take_b, take_call, take_ret, redirect;
   logic        overflow, underflow;
   logic [15:0] b_target, call_target, ret_link, ras_top;

   assign opcode      = ex_instr[15:12];
   assign is_b        = (opcode == OP_B);
   assign is_call     = (opcode == OP_CALL);
   assign is_ret      = (opcode == OP_RET);
   assign b_target    = ex_pc + 16'd2 + sext8(ex_instr[7:0]);
   assign call_target = {ex_pc[15:12], ex_instr[11:0]};
   assign ret_link    = ex_pc + 16'd2;

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .AW    (RAS_AW)
   ) u_ras (
      .clk   (clk),
      .rst   (rst),
      .push  (take_call),
      .pop   (take_ret),
      .din   (ret_link),
      .top   (ras_top),
      .empty (ras_empty),
      .full  (ras_full)
   );

   // Redirect decode; a CALL on a full stack or RET on an empty one faults instead.
   always_comb begin
      take_b    = 1'b0;
      take_call = 1'b0;
      take_ret  = 1'b0;
      overflow  = 1'b0;
      underflow = 1'b0;
      if (state_q == ST_RUN && ex_valid) begin
         if (is_b) begin
            take_b = branch;
         end else if (is_call) begin
            overflow  = ras_full;
            take_call = ~ras_full;
         end else if (is_ret) begin
            underflow = ras_empty;
            take_ret  = ~ras_empty;
         end
      end
   end

   assign redirect = take_b | take_call | take_ret;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT:  state_d = ST_RUN;
         ST_RUN:   if (overflow || underflow) state_d = ST_FAULT;
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_BOOT;
      endcase
   end

   // Redirects take precedence over the hazard hold.
   always_comb begin
      pc_d    = pc_q;
      fault_d = fault_q | overflow | underflow;
      if (take_b)
         pc_d = b_target;
      else if (take_call)
         pc_d = call_target;
      else if (take_ret)
         pc_d = ras_top;
      else if (state_q == ST_RUN && !hazard && !overflow && !underflow)
         pc_d = pc_q + 16'd1;
   end

   always_comb begin
      if_valid = (state_q == ST_RUN);
      flush_if = redirect;
   end

   assign if_pc = pc_q;
   assign fault = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, hazard, branches, CALL/RET, RAS overflow/underflow, wrap.
module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst, hazard, ex_valid, branch;
   logic [15:0] ex_pc, ex_instr;
   logic [15:0] if_pc;
   logic        if_valid, flush_if, ras_empty, ras_full, fault;

   int n_chk  = 0;
   int n_pass = 0;

   pc_sequencer #(
      .RESET_PC  (16'h0000),
      .RAS_DEPTH (8),
      .RAS_AW    (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .hazard    (hazard),
      .ex_valid  (ex_valid),
      .ex_pc     (ex_pc),
      .ex_instr  (ex_instr),
      .branch    (branch),
      .if_pc     (if_pc),
      .if_valid  (if_valid),
      .flush_if  (flush_if),
      .ras_empty (ras_empty),
      .ras_full  (ras_full),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic ex_set(input logic v, input logic [15:0] pc, input logic [15:0] instr, input logic br);
      ex_valid = v;
      ex_pc    = pc;
      ex_instr = instr;
      branch   = br;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; hazard = 1'b0;
      ex_set(1'b0, 16'h0000, 16'h0000, 1'b0);
      tick(); tick();
      chk("rst_pc", if_pc, 16'h0000);
      chk("rst_valid", {15'd0, if_valid}, 16'd0);
      chk("rst_flush", {15'd0, flush_if}, 16'd0);
      chk("rst_fault", {15'd0, fault}, 16'd0);
      chk("rst_empty", {15'd0, ras_empty}, 16'd1);
      chk("rst_full", {15'd0, ras_full}, 16'd0);

      // 1: BOOT then sequential fetch
      rst = 1'b0; settle();
      chk("boot_pc", if_pc, 16'h0000);
      chk("boot_valid", {15'd0, if_valid}, 16'd0);
      tick(); chk("run0_pc", if_pc, 16'h0000); chk("run0_valid", {15'd0, if_valid}, 16'd1);
      tick(); chk("run1_pc", if_pc, 16'h0001);
      tick(); chk("run2_pc", if_pc, 16'h0002);
      tick(); chk("run3_pc", if_pc, 16'h0003); chk("run3_valid", {15'd0, if_valid}, 16'd1);

      // 2: hazard hold at 0010
      for (int i = 0; i < 13; i++) tick();
      chk("pre_hz_pc", if_pc, 16'h0010);
      hazard = 1'b1; settle();
      chk("hz_flush", {15'd0, flush_if}, 16'd0);
      tick(); chk("hz1_pc", if_pc, 16'h0010);
      tick(); chk("hz2_pc", if_pc, 16'h0010);
      hazard = 1'b0;
      tick(); chk("hz_rel_pc", if_pc, 16'h0011);

      // 3: taken B backwards, then not-taken B
      ex_set(1'b1, 16'h0020, {OP_B, 4'h0, 8'hFE}, 1'b1); settle();
      chk("b_taken_flush", {15'd0, flush_if}, 16'd1);
      tick(); chk("b_taken_pc", if_pc, 16'h0020);
      ex_set(1'b1, 16'h0020, {OP_B, 4'h0, 8'hFE}, 1'b0); settle();
      chk("b_nt_flush", {15'd0, flush_if}, 16'd0);
      tick(); chk("b_nt_pc", if_pc, 16'h0021);
      chk("b_nt_empty", {15'd0, ras_empty}, 16'd1);

      // 4: CALL / nested CALL / RET / RET (LIFO)
      ex_set(1'b1, 16'h3040, {OP_CALL, 12'h155}, 1'b0); settle();
      chk("call_flush", {15'd0, flush_if}, 16'd1);
      tick(); chk("call_pc", if_pc, 16'h3155); chk("call_empty", {15'd0, ras_empty}, 16'd0);
      ex_set(1'b1, 16'h0500, {OP_CALL, 12'h234}, 1'b0);
      tick(); chk("call2_pc", if_pc, 16'h0234);
      ex_set(1'b0, 16'h0000, 16'h0000, 1'b0);
      tick(); chk("idle_pc", if_pc, 16'h0235);
      ex_set(1'b1, 16'h0236, {OP_RET, 12'h000}, 1'b0); settle();
      chk("ret_flush", {15'd0, flush_if}, 16'd1);
      tick(); chk("ret1_pc", if_pc, 16'h0502);
      ex_set(1'b1, 16'h0503, {OP_RET, 12'h000}, 1'b0);
      tick(); chk("ret2_pc", if_pc, 16'h3042); chk("ret2_empty", {15'd0, ras_empty}, 16'd1);
      ex_set(1'b0, 16'h0000, 16'h0000, 1'b0);

      // 5: fill the RAS, overflow on the ninth CALL
      for (int i = 0; i < 8; i++) begin
         ex_set(1'b1, 16'h2000 + 16'(i), {OP_CALL, 12'h400 + 12'(i)}, 1'b0);
         if (i == 7) begin settle(); chk("full_before8", {15'd0, ras_full}, 16'd0); end
         tick();
      end
      chk("fill_pc", if_pc, 16'h2407);
      chk("fill_full", {15'd0, ras_full}, 16'd1);
      ex_set(1'b1, 16'h2100, {OP_CALL, 12'h777}, 1'b0); settle();
      chk("ovf_flush", {15'd0, flush_if}, 16'd0);
      tick();
      chk("ovf_fault", {15'd0, fault}, 16'd1);
      chk("ovf_valid", {15'd0, if_valid}, 16'd0);
      chk("ovf_pc", if_pc, 16'h2407);
      ex_set(1'b1, 16'h2101, {OP_RET, 12'h000}, 1'b0); settle();
      chk("fault_ret_flush", {15'd0, flush_if}, 16'd0);
      tick(); tick();
      chk("fault_pc_held", if_pc, 16'h2407);
      chk("fault_ras_frozen", {15'd0, ras_full}, 16'd1);
      chk("fault_sticky", {15'd0, fault}, 16'd1);
      rst = 1'b1;
      tick();
      chk("rst2_pc", if_pc, 16'h0000);
      chk("rst2_fault", {15'd0, fault}, 16'd0);
      chk("rst2_valid", {15'd0, if_valid}, 16'd0);
      chk("rst2_empty", {15'd0, ras_empty}, 16'd1);
      chk("rst2_full", {15'd0, ras_full}, 16'd0);
      rst = 1'b0;
      ex_set(1'b0, 16'h0000, 16'h0000, 1'b0);
      tick(); chk("reboot_valid", {15'd0, if_valid}, 16'd1);

      // 6: wrap-around branch under hazard, ignored bubble, RET underflow
      hazard = 1'b1;
      ex_set(1'b1, 16'hFFFF, {OP_B, 4'h0, 8'h01}, 1'b1); settle();
      chk("wrap_flush", {15'd0, flush_if}, 16'd1);
      tick(); chk("wrap_pc", if_pc, 16'h0002);
      hazard = 1'b0;
      ex_set(1'b0, 16'hFFFF, {OP_B, 4'h0, 8'h01}, 1'b1); settle();
      chk("bubble_flush", {15'd0, flush_if}, 16'd0);
      tick(); chk("bubble_pc", if_pc, 16'h0003);
      ex_set(1'b1, 16'h0004, {OP_RET, 12'h000}, 1'b0); settle();
      chk("udf_flush", {15'd0, flush_if}, 16'd0);
      tick();
      chk("udf_fault", {15'd0, fault}, 16'd1);
      chk("udf_pc", if_pc, 16'h0003);
      chk("udf_valid", {15'd0, if_valid}, 16'd0);
      rst = 1'b1;
      tick();
      chk("rst3_fault", {15'd0, fault}, 16'd0);
      chk("rst3_pc", if_pc, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
